// File: rtl/cpu_pkg.sv
// Shared CPU definitions: immediate-format codes and instruction/field widths.
// The decoder that produces ImmSrc imports the same enum.
package cpu_pkg;

  typedef enum logic [1:0] {
    IMM15 = 2'b00,
    IMM19 = 2'b01,
    IMM23 = 2'b10,
    IMM27 = 2'b11
  } imm_src_t;

  localparam int INSTR_W = 32;
  localparam int IMM15_W = 15;
  localparam int IMM19_W = 19;
  localparam int IMM23_W = 23;
  localparam int IMM27_W = 27;

endpackage

// File: rtl/imm_extender_core.sv
// Combinational field select and sign/zero extension of a registered
// immediate field (the opcode-free low 27 bits of the instruction).
module imm_ext_core
  import cpu_pkg::*;
(
  input  logic [IMM27_W-1:0] field,
  input  imm_src_t           src,
  input  logic               sext,
  output logic [INSTR_W-1:0] ext
);

  logic sign;

  always_comb begin
    sign = 1'b0;
    ext  = '0;
    unique case (src)
      IMM15: begin
        sign = sext & field[IMM15_W-1];
        ext  = {{(INSTR_W-IMM15_W){sign}}, field[IMM15_W-1:0]};
      end
      IMM19: begin
        sign = sext & field[IMM19_W-1];
        ext  = {{(INSTR_W-IMM19_W){sign}}, field[IMM19_W-1:0]};
      end
      IMM23: begin
        sign = sext & field[IMM23_W-1];
        ext  = {{(INSTR_W-IMM23_W){sign}}, field[IMM23_W-1:0]};
      end
      IMM27: begin
        sign = sext & field[IMM27_W-1];
        ext  = {{(INSTR_W-IMM27_W){sign}}, field[IMM27_W-1:0]};
      end
      default: begin
        sign = 1'b0;
        ext  = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_extender.sv
// Two-stage immediate extender between decode and the execute operand mux.
// S1 captures the immediate field and controls, S2 holds the extended result.
module imm_extender
  import cpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Flush,
  input  logic               InValid,
  output logic               InReady,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [1:0]         ImmSrc,
  input  logic               SignExt,
  input  logic [TAG_W-1:0]   TagIn,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [INSTR_W-1:0] ExtImm,
  output logic [TAG_W-1:0]   TagOut
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and the only combinational path
  // through the unit is OutReady -> InReady.

  logic               s1_v;
  logic [IMM27_W-1:0] s1_field;
  imm_src_t           s1_src;
  logic               s1_sext;
  logic [TAG_W-1:0]   s1_tag;

  logic               s2_v;
  logic [INSTR_W-1:0] s2_imm;
  logic [TAG_W-1:0]   s2_tag;

  logic               s1_adv;
  logic               s2_adv;
  logic               in_xfer;
  logic [INSTR_W-1:0] core_ext;

  // Opcode bits are intentionally never stored.
  logic unused_opcode;
  assign unused_opcode = ^Instr[INSTR_W-1:IMM27_W];

  assign s2_adv  = !s2_v || OutReady;
  assign s1_adv  = !s1_v || s2_adv;
  assign InReady = s1_adv && rst;
  assign in_xfer = InValid && InReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v     <= 1'b0;
      s1_field <= '0;
      s1_src   <= IMM15;
      s1_sext  <= 1'b0;
      s1_tag   <= '0;
    end else begin
      if (Flush) begin
        s1_v <= 1'b0;
      end else if (s1_adv) begin
        s1_v <= in_xfer;
      end
      if (in_xfer && !Flush) begin
        s1_field <= Instr[IMM27_W-1:0];
        s1_src   <= imm_src_t'(ImmSrc);
        s1_sext  <= SignExt;
        s1_tag   <= TagIn;
      end
    end
  end

  imm_ext_core u_core (
    .field (s1_field),
    .src   (s1_src),
    .sext  (s1_sext),
    .ext   (core_ext)
  );

  // An empty S2 pulls from S1 regardless of OutReady, so bubbles collapse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_v   <= 1'b0;
      s2_imm <= '0;
      s2_tag <= '0;
    end else begin
      if (Flush) begin
        s2_v <= 1'b0;
      end else if (s2_adv) begin
        s2_v <= s1_v;
      end
      if (s2_adv && s1_v && !Flush) begin
        s2_imm <= core_ext;
        s2_tag <= s1_tag;
      end
    end
  end

  assign OutValid = s2_v;
  assign ExtImm   = s2_imm;
  assign TagOut   = s2_tag;

endmodule

// File: tb/tb_imm_extender.sv
// Self-checking bench for imm_extender: directed spec vectors, streaming,
// back-pressure, flush and asynchronous reset, with a queue scoreboard.
module tb_imm_extender;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             Flush = 1'b0;
  logic             InValid = 1'b0;
  logic             InReady;
  logic [31:0]      Instr = '0;
  logic [1:0]       ImmSrc = '0;
  logic             SignExt = 1'b0;
  logic [TAG_W-1:0] TagIn = '0;
  logic             OutValid;
  logic             OutReady = 1'b0;
  logic [31:0]      ExtImm;
  logic [TAG_W-1:0] TagOut;

  int total = 0;
  int bad = 0;
  int out_count = 0;
  logic [TAG_W+31:0] exp_q[$];

  imm_extender #(.TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .Instr    (Instr),
    .ImmSrc   (ImmSrc),
    .SignExt  (SignExt),
    .TagIn    (TagIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .ExtImm   (ExtImm),
    .TagOut   (TagOut)
  );

  always #5 clk = ~clk;

  // Reference: mask the field by width, then OR in the upper ones if negative.
  function automatic logic [31:0] model(input logic [31:0] instr,
                                        input logic [1:0] src,
                                        input logic sext);
    int w;
    logic [31:0] mask;
    logic [31:0] f;
    w = 15 + 4 * int'(src);
    mask = (32'h1 << w) - 32'h1;
    f = instr & mask;
    if (sext && f[w-1]) f = f | ~mask;
    return f;
  endfunction

  // One cycle: scoreboard at the negedge, then return 1ns after the posedge.
  task automatic tick();
    logic [TAG_W+31:0] e;
    @(negedge clk);
    if (rst) begin
      if (OutValid && OutReady) begin
        out_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected got tag=%0d imm=%h required none", TagOut, ExtImm);
        end else begin
          e = exp_q.pop_front();
          if ({TagOut, ExtImm} !== e) begin
            bad++;
            $display("FAIL out_data got tag=%0d imm=%h required tag=%0d imm=%h",
                     TagOut, ExtImm, e[TAG_W+31:32], e[31:0]);
          end
        end
      end
      if (Flush) exp_q.delete();
      else if (InValid && InReady) exp_q.push_back({TagIn, model(Instr, ImmSrc, SignExt)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    InValid = 1'b0;
    OutReady = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL rst_outvalid got %b required 0", OutValid); end
    total++; if (ExtImm !== 32'h0) begin bad++; $display("FAIL rst_extimm got %h required 0", ExtImm); end
    total++; if (TagOut !== '0) begin bad++; $display("FAIL rst_tag got %0d required 0", TagOut); end
    total++; if (InReady !== 1'b0) begin bad++; $display("FAIL rst_inready got %b required 0", InReady); end
    rst = 1'b1;
    #1;
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL idle_inready got %b required 1", InReady); end
    tick();
  endtask

  // Single instruction, checking 2-edge latency and the spec's expected value.
  task automatic test_single(input logic [31:0] instr, input logic [1:0] src,
                             input logic sext, input logic [TAG_W-1:0] tag,
                             input logic [31:0] want);
    OutReady = 1'b1;
    InValid = 1'b1; Instr = instr; ImmSrc = src; SignExt = sext; TagIn = tag;
    tick();
    InValid = 1'b0;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL lat_early got %b required 0", OutValid); end
    tick();
    total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL lat_valid got %b required 1", OutValid); end
    total++; if (ExtImm !== want) begin bad++; $display("FAIL imm_%h got %h required %h", instr, ExtImm, want); end
    total++; if (TagOut !== tag) begin bad++; $display("FAIL tag got %0d required %0d", TagOut, tag); end
    drain(4);
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      InValid = 1'b1;
      Instr = $urandom();
      ImmSrc = 2'(i);
      SignExt = 1'($urandom_range(0, 1));
      TagIn = TAG_W'(i + 8);
      total++; if (InReady !== 1'b1) begin bad++; $display("FAIL b2b_inready[%0d] got %b required 1", i, InReady); end
      if (i >= 2) begin
        total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL b2b_bubble[%0d] got %b required 1", i, OutValid); end
      end
      tick();
    end
    InValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL b2b_tail[%0d] got %b required 1", i, OutValid); end
      tick();
    end
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL b2b_end got %b required 0", OutValid); end
    drain(4);
  endtask

  task automatic test_backpressure();
    int accepts;
    int start_out;
    logic [31:0] held;
    accepts = 0;
    OutReady = 1'b0;
    InValid = 1'b1;
    Instr = $urandom(); ImmSrc = 2'($urandom_range(0, 3)); SignExt = 1'b1; TagIn = 5'd20;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) held = ExtImm;
      if (c > 2) begin
        total++; if (ExtImm !== held) begin bad++; $display("FAIL bp_stable[%0d] got %h required %h", c, ExtImm, held); end
      end
      if (InReady) begin
        accepts++;
        tick();
        Instr = $urandom(); ImmSrc = 2'($urandom_range(0, 3)); SignExt = 1'($urandom_range(0, 1));
        TagIn = TagIn + 5'd1;
      end else begin
        tick();
      end
    end
    total++; if (accepts != 2) begin bad++; $display("FAIL bp_accepts got %0d required 2", accepts); end
    total++; if (InReady !== 1'b0) begin bad++; $display("FAIL bp_inready got %b required 0", InReady); end
    start_out = out_count;
    drain(6);
    total++; if (out_count - start_out != 2) begin bad++; $display("FAIL bp_delivered got %0d required 2", out_count - start_out); end
  endtask

  task automatic test_flush();
    int start_out;
    OutReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      InValid = 1'b1; Instr = $urandom(); ImmSrc = 2'($urandom_range(0, 3));
      SignExt = 1'b1; TagIn = TAG_W'(i + 1);
      tick();
    end
    start_out = out_count;
    OutReady = 1'b1; InValid = 1'b1; Flush = 1'b1;
    Instr = 32'h0000_7FFF; ImmSrc = 2'b00; TagIn = 5'd31;
    tick();
    Flush = 1'b0; InValid = 1'b0;
    total++; if (out_count - start_out != 1) begin bad++; $display("FAIL flush_consumed got %0d required 1", out_count - start_out); end
    for (int i = 0; i < 3; i++) begin
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL flush_outvalid[%0d] got %b required 0", i, OutValid); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] instr;
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InValid = 1'b1; Instr = $urandom(); ImmSrc = 2'($urandom_range(0, 3));
      SignExt = 1'b1; TagIn = TAG_W'(i + 12);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    InValid = 1'b0;
    exp_q.delete();
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL arst_outvalid got %b required 0", OutValid); end
    total++; if (ExtImm !== 32'h0) begin bad++; $display("FAIL arst_extimm got %h required 0", ExtImm); end
    total++; if (InReady !== 1'b0) begin bad++; $display("FAIL arst_inready got %b required 0", InReady); end
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    instr = $urandom();
    test_single(instr, 2'b10, 1'b1, 5'd7, model(instr, 2'b10, 1'b1));
  endtask

  initial begin
    test_reset();
    test_single(32'h0000_4000, 2'b00, 1'b1, 5'd3, 32'hFFFF_C000);
    test_single(32'h0000_4000, 2'b00, 1'b0, 5'd3, 32'h0000_4000);
    test_single(32'hF804_0000, 2'b01, 1'b1, 5'd4, 32'hFFFC_0000);
    test_single(32'hFC00_0001, 2'b11, 1'b1, 5'd5, 32'hFC00_0001);
    test_single(32'hFC00_0001, 2'b11, 1'b0, 5'd6, 32'h0400_0001);
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_extender.md
# imm_extender

Pipelined immediate-extension unit that consumes the 2-bit immediate-format code produced by the instruction decoder. It extracts the 15/19/23/27-bit immediate field from a 32-bit instruction word and returns a sign- or zero-extended 32-bit operand. It sits between the decode stage and the execute operand mux, and uses valid/ready handshakes on both sides so decode stalls and flushes propagate cleanly.

## Interface

Parameters:
- TAG_W, default 5: width of the sideband tag carried alongside each instruction, such as the destination register index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous pipeline flush.
- InValid  in  1  the upstream instruction is valid.
- InReady  out  1  the unit accepts an instruction this cycle.
- Instr  in  32  instruction word; opcode in [31:27].
- ImmSrc  in  2  immediate format from the decoder:
  - 00: 15-bit field
  - 01: 19-bit field
  - 10: 23-bit field
  - 11: 27-bit field
- SignExt  in  1  1 selects sign extension; 0 selects zero extension.
- TagIn  in  TAG_W  sideband tag.
- OutValid  out  1  ExtImm and TagOut are valid.
- OutReady  in  1  the downstream stage consumes the output this cycle.
- ExtImm  out  32  extended immediate.
- TagOut  out  TAG_W  tag that accompanies ExtImm.

## Operation

- Input transfer occurs when InValid && InReady; output transfer occurs when OutValid && OutReady.
- Field selection by ImmSrc:
  - 00 → Instr[14:0]
  - 01 → Instr[18:0]
  - 10 → Instr[22:0]
  - 11 → Instr[26:0]
- Extension of the selected field:
  - SignExt=1: the field MSB is replicated into all higher bits.
  - SignExt=0: the higher bits are zero.
- Opcode bits [31:27] never appear in ExtImm. They enter only through sign replication when ImmSrc=11 and bit 26 is set.
- Stage 1 (S1) registers the selected field, ImmSrc, SignExt and TagIn, together with a valid bit s1_v.
- Stage 2 (S2) registers the extended result and the tag, together with a valid bit s2_v. OutValid = s2_v.
- Advance rules:
  - s2_adv = !s2_v || OutReady
  - s1_adv = !s1_v || s2_adv
  - InReady = s1_adv while rst is high; InReady = 0 while rst is low.
- S1 loads on an input transfer. S1 clears when it hands its entry to S2 and no new input arrives.
- Bubbles collapse: an empty S2 accepts from S1 regardless of OutReady.
- Flush=1 clears s1_v and s2_v at the next edge.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts as consumed.
- Reset, asynchronous and active-low:
  - s1_v=0, s2_v=0, so OutValid=0.
  - ExtImm=32'h0, TagOut=0, all S1 data registers 0.
- Reset asserted mid-operation drops all in-flight entries immediately. No partial output is ever presented.

## Timing

- Latency: ExtImm is valid 2 cycles after the accepting edge, provided the pipeline is not back-pressured.
- Throughput: 1 instruction per cycle while OutReady=1.
- Back-pressure: OutReady=0 with s2_v=1 holds S2. S1 fills, then InReady drops combinationally in the same cycle S1 is full. Full = 2 entries held.
- Held output: while OutValid=1 and OutReady=0, ExtImm and TagOut are stable.
- Simultaneous events: OutReady=1 on a full pipeline, with InValid=1 in the same cycle, shifts all stages with no bubble and no loss.
- Empty pipeline: InReady=1. OutValid stays 0 until 2 edges after the first accept.
- Only combinational input-to-output path: OutReady → InReady. No path runs from Instr to ExtImm.

## Structure

- Shared package cpu_pkg holds:
  - imm_src_t enum: IMM15=2'b00, IMM19=2'b01, IMM23=2'b10, IMM27=2'b11.
  - Width constants IMM15_W=15, IMM19_W=19, IMM23_W=23, IMM27_W=27 and INSTR_W=32.
- The decoder that drives ImmSrc also imports imm_src_t from cpu_pkg.
- Sub-module imm_ext_core holds the purely combinational field select and extension; it is instantiated between S1 and S2.
- The handshake and valid logic stay in imm_extender.

## Test plan

- Reset, then ImmSrc=00, SignExt=1, Instr=32'h0000_4000, TagIn=3 → 2 cycles later OutValid=1, ExtImm=32'hFFFF_C000, TagOut=3. With SignExt=0 the same input gives 32'h0000_4000.
- ImmSrc=01, SignExt=1, Instr=32'hF804_0000 → ExtImm=32'hFFFC_0000. ImmSrc=11, Instr=32'hFC00_0001 gives 32'hFC00_0001 with SignExt=1 and 32'h0400_0001 with SignExt=0.
- Streaming with OutReady=1 and 4 back-to-back instructions, each with a distinct ImmSrc → 4 consecutive OutValid cycles, in order, with no bubbles and correct values.
- OutReady=0 for 5 cycles while InValid=1 → InReady drops after 2 accepts. ExtImm stays stable. Releasing OutReady delivers both held entries in order with no loss or duplicate.
- Flush with both stages full, with InValid=1 and OutReady=1 in the same cycle → the current output is counted as consumed, the next cycle shows OutValid=0, and the flush-cycle input never appears.
- rst pulled low mid-stream, asynchronously between edges → OutValid=0 and ExtImm=0 immediately. After release, the first new input emerges 2 cycles after acceptance.
